// File: rtl/hx711_reader.sv
// HX711 load-cell ADC reader: clocks out 24 bits plus gain pulses, subtracts tare, clamps to unsigned.
// Latency: data_valid pulses 1 cycle after the last gain low phase; no backpressure, power_down aborts a read.
module hx711_reader #(
  parameter int SCK_HALF_CYCLES = 50,
  parameter int GAIN_PULSES     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        hx_dout,
  output logic        hx_sck,
  input  logic        tare_req,
  input  logic        power_down,
  output logic [23:0] raw_data,
  output logic [23:0] weight_out,
  output logic        data_valid,
  output logic        busy
);

  localparam int PW = $clog2(SCK_HALF_CYCLES);

  typedef enum logic [2:0] {
    WAIT_READY, SHIFT_HI, SHIFT_LO, GAIN_HI, GAIN_LO, COMMIT, WAIT_HIGH, PWR_DOWN
  } state_t;

  state_t        state, state_nxt;
  logic          dout_meta, dout_s;
  logic [PW-1:0] phase_cnt;
  logic [4:0]    bit_cnt;
  logic [1:0]    pulse_cnt;
  logic [23:0]   shreg;
  logic [23:0]   tare;
  logic          tare_armed;
  logic          phase_end;
  logic [24:0]   diff;

  assign phase_end = (phase_cnt == PW'(SCK_HALF_CYCLES - 1));
  assign diff      = {shreg[23], shreg} - {tare[23], tare};
  assign busy      = (state == SHIFT_HI) || (state == SHIFT_LO) ||
                     (state == GAIN_HI)  || (state == GAIN_LO);

  // DOUT idles high, so the synchroniser resets high to avoid a false start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout_meta <= 1'b1;
      dout_s    <= 1'b1;
    end else begin
      dout_meta <= hx_dout;
      dout_s    <= dout_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= WAIT_READY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_READY: if (!dout_s)   state_nxt = SHIFT_HI;
      SHIFT_HI:   if (phase_end) state_nxt = SHIFT_LO;
      SHIFT_LO:   if (phase_end) state_nxt = (bit_cnt == 5'd24) ? GAIN_HI : SHIFT_HI;
      GAIN_HI:    if (phase_end) state_nxt = GAIN_LO;
      GAIN_LO:    if (phase_end) state_nxt = (pulse_cnt == 2'(GAIN_PULSES)) ? COMMIT : GAIN_HI;
      COMMIT:     state_nxt = WAIT_HIGH;
      WAIT_HIGH:  if (dout_s)    state_nxt = WAIT_READY;
      PWR_DOWN:   if (!power_down) state_nxt = WAIT_HIGH;
      default:    state_nxt = WAIT_READY;
    endcase
    if (power_down) state_nxt = PWR_DOWN;
  end

  // PD_SCK is derived from the next state so the pin is a clean flop output aligned to the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hx_sck    <= 1'b0;
      phase_cnt <= '0;
    end else begin
      hx_sck <= (state_nxt == SHIFT_HI) || (state_nxt == GAIN_HI) || (state_nxt == PWR_DOWN);
      if (state_nxt != state || !busy) phase_cnt <= '0;
      else                             phase_cnt <= phase_cnt + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      pulse_cnt  <= '0;
      shreg      <= '0;
      tare       <= '0;
      tare_armed <= 1'b0;
      raw_data   <= '0;
      weight_out <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (tare_req) tare_armed <= 1'b1;
      if (state == WAIT_READY) bit_cnt <= '0;
      if (state == SHIFT_HI && phase_end) begin
        shreg   <= {shreg[22:0], dout_s};
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (state == SHIFT_LO) pulse_cnt <= '0;
      if (state == GAIN_HI && phase_end) pulse_cnt <= pulse_cnt + 2'd1;
      if (state == COMMIT) begin
        raw_data   <= shreg;
        data_valid <= 1'b1;
        // A tare request landing on the commit cycle still applies to this sample.
        if (tare_armed || tare_req) begin
          tare       <= shreg;
          weight_out <= '0;
          tare_armed <= 1'b0;
        end else begin
          weight_out <= diff[24] ? 24'd0 : diff[23:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_hx711_reader.sv
// Bench for hx711_reader: plays the HX711 serial protocol and checks samples against an arithmetic tare/clamp model.
module tb_hx711_reader;

  localparam int HALF = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        hx_dout = 1'b1, tare_req = 1'b0, power_down = 1'b0;
  logic        hx_sck, data_valid, busy;
  logic [23:0] raw_data, weight_out;

  logic        hx_dout3 = 1'b1, tare_req3 = 1'b0, power_down3 = 1'b0;
  logic        hx_sck3, dv3, busy3;
  logic [23:0] raw3, weight3;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] m_tare = 24'd0;
  bit          m_armed = 1'b0;

  always #5 clock = ~clock;

  hx711_reader #(.SCK_HALF_CYCLES(HALF), .GAIN_PULSES(1)) dut (
    .clock(clock), .reset_n(reset_n), .hx_dout(hx_dout), .hx_sck(hx_sck),
    .tare_req(tare_req), .power_down(power_down), .raw_data(raw_data),
    .weight_out(weight_out), .data_valid(data_valid), .busy(busy)
  );

  hx711_reader #(.SCK_HALF_CYCLES(HALF), .GAIN_PULSES(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .hx_dout(hx_dout3), .hx_sck(hx_sck3),
    .tare_req(tare_req3), .power_down(power_down3), .raw_data(raw3),
    .weight_out(weight3), .data_valid(dv3), .busy(busy3)
  );

  // HX711 behaviour: DOUT low = ready; each PD_SCK rise presents the next bit MSB first,
  // and after 24 bits DOUT is released high.
  task automatic run_read(input bit sel, input logic [23:0] w, input int stop_at,
                          output int pulses, output bit got_dv);
    bit prev, sck, dv;
    pulses = 0;
    got_dv = 1'b0;
    repeat (4) @(negedge clock);
    prev = sel ? hx_sck3 : hx_sck;
    if (sel) hx_dout3 = 1'b0; else hx_dout = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      sck = sel ? hx_sck3 : hx_sck;
      dv  = sel ? dv3 : data_valid;
      if (sck && !prev) begin
        if (pulses < 24) begin
          if (sel) hx_dout3 = w[23 - pulses]; else hx_dout = w[23 - pulses];
        end else begin
          if (sel) hx_dout3 = 1'b1; else hx_dout = 1'b1;
        end
        pulses++;
      end
      prev = sck;
      if (dv) begin
        got_dv = 1'b1;
        break;
      end
      if (stop_at > 0 && pulses >= stop_at) break;
    end
  endtask

  task automatic do_sample(input bit sel, input logic [23:0] w, output int pulses,
                           output bit got_dv, output bit dv_after);
    run_read(sel, w, 0, pulses, got_dv);
    @(negedge clock);
    dv_after = sel ? dv3 : data_valid;
  endtask

  // Reference: weight = max(signed(raw) - signed(tare), 0); an armed tare captures the sample instead.
  task automatic model_commit(input logic [23:0] w, output logic [23:0] exp_w);
    int rs, ts, d;
    if (m_armed) begin
      m_tare  = w;
      m_armed = 1'b0;
      exp_w   = 24'd0;
    end else begin
      rs = $signed(w);
      ts = $signed(m_tare);
      d  = rs - ts;
      exp_w = (d < 0) ? 24'd0 : d[23:0];
    end
  endtask

  task automatic pulse_tare();
    @(negedge clock);
    tare_req = 1'b1;
    @(negedge clock);
    tare_req = 1'b0;
    m_armed = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (hx_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", hx_sck); end
    checks++; if (raw_data !== 24'd0) begin errors++; $display("FAIL reset_raw: got %h want 000000", raw_data); end
    checks++; if (weight_out !== 24'd0) begin errors++; $display("FAIL reset_weight: got %h want 000000", weight_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_basic();
    int p; bit got, after; logic [23:0] e;
    do_sample(0, 24'h000400, p, got, after);
    model_commit(24'h000400, e);
    checks++; if (!got) begin errors++; $display("FAIL basic_dv: no data_valid seen"); end
    checks++; if (p != 25) begin errors++; $display("FAIL basic_pulses: got %0d want 25", p); end
    checks++; if (raw_data !== 24'h000400) begin errors++; $display("FAIL basic_raw: got %h want 000400", raw_data); end
    checks++; if (weight_out !== e) begin errors++; $display("FAIL basic_weight: got %0d want %0d", weight_out, e); end
    checks++; if (after !== 1'b0) begin errors++; $display("FAIL basic_dv_width: dv still %b next cycle, want 0", after); end
  endtask

  task automatic test_negative();
    int p; bit got, after; logic [23:0] e;
    do_sample(0, 24'hFFFFF0, p, got, after);
    model_commit(24'hFFFFF0, e);
    checks++; if (!got) begin errors++; $display("FAIL neg_dv: no data_valid seen"); end
    checks++; if (raw_data !== 24'hFFFFF0) begin errors++; $display("FAIL neg_raw: got %h want fffff0", raw_data); end
    checks++; if (weight_out !== e) begin errors++; $display("FAIL neg_weight: got %h want %h", weight_out, e); end
  endtask

  task automatic test_tare();
    int p; bit got, after; logic [23:0] e;
    pulse_tare();
    do_sample(0, 24'h001000, p, got, after);
    model_commit(24'h001000, e);
    checks++; if (!got || weight_out !== e) begin errors++; $display("FAIL tare_capture: got %h want %h (dv %b)", weight_out, e, got); end
    do_sample(0, 24'h001234, p, got, after);
    model_commit(24'h001234, e);
    checks++; if (!got || weight_out !== e) begin errors++; $display("FAIL tare_apply: got %h want %h (dv %b)", weight_out, e, got); end
  endtask

  task automatic test_no_wrap();
    int p; bit got, after; logic [23:0] e;
    pulse_tare();
    do_sample(0, 24'h800000, p, got, after);
    model_commit(24'h800000, e);
    do_sample(0, 24'h7FFFFF, p, got, after);
    model_commit(24'h7FFFFF, e);
    checks++; if (!got || weight_out !== e) begin errors++; $display("FAIL no_wrap: got %h want %h (dv %b)", weight_out, e, got); end
  endtask

  task automatic test_gain3();
    int p; bit got, after; logic [23:0] w, e;
    w = 24'($urandom);
    e = w[23] ? 24'd0 : w;
    do_sample(1, w, p, got, after);
    checks++; if (!got) begin errors++; $display("FAIL gain3_dv: no data_valid seen"); end
    checks++; if (p != 27) begin errors++; $display("FAIL gain3_pulses: got %0d want 27", p); end
    checks++; if (raw3 !== w) begin errors++; $display("FAIL gain3_raw: got %h want %h", raw3, w); end
    checks++; if (weight3 !== e) begin errors++; $display("FAIL gain3_weight: got %h want %h", weight3, e); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL gain3_busy: got %b want 0", busy3); end
  endtask

  task automatic test_random();
    int p; bit got, after; logic [23:0] w, e;
    for (int i = 0; i < 8; i++) begin
      w = 24'($urandom);
      if ($urandom_range(0, 3) == 0) pulse_tare();
      do_sample(0, w, p, got, after);
      model_commit(w, e);
      checks++; if (!got || raw_data !== w) begin errors++; $display("FAIL rand_raw[%0d]: got %h want %h (dv %b)", i, raw_data, w, got); end
      checks++; if (weight_out !== e) begin errors++; $display("FAIL rand_weight[%0d]: got %h want %h", i, weight_out, e); end
    end
  endtask

  task automatic test_power_down();
    int p, dv_cnt; bit got, after; logic [23:0] w, old_raw, e;
    old_raw = raw_data;
    w = 24'($urandom);
    run_read(0, w, 10, p, got);
    power_down = 1'b1;
    dv_cnt = 0;
    repeat (3) @(negedge clock);
    checks++; if (hx_sck !== 1'b1) begin errors++; $display("FAIL pd_sck_high: got %b want 1", hx_sck); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pd_busy: got %b want 0", busy); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (data_valid) dv_cnt++;
    end
    checks++; if (dv_cnt != 0 || got) begin errors++; $display("FAIL pd_no_dv: got %0d pulses want 0", dv_cnt); end
    checks++; if (raw_data !== old_raw) begin errors++; $display("FAIL pd_raw_kept: got %h want %h", raw_data, old_raw); end
    power_down = 1'b0;
    hx_dout = 1'b1;
    repeat (5) @(negedge clock);
    checks++; if (hx_sck !== 1'b0) begin errors++; $display("FAIL pd_release_sck: got %b want 0", hx_sck); end
    w = 24'($urandom);
    do_sample(0, w, p, got, after);
    model_commit(w, e);
    checks++; if (!got || raw_data !== w || weight_out !== e) begin
      errors++; $display("FAIL pd_after_read: raw %h weight %h want %h %h (dv %b)", raw_data, weight_out, w, e, got);
    end
  endtask

  task automatic test_reset_mid();
    int p; bit got, after; logic [23:0] w, e;
    run_read(0, 24'h5A5A5A, 12, p, got);
    reset_n = 1'b0;
    #1;
    checks++; if (hx_sck !== 1'b0 || busy !== 1'b0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: sck %b busy %b dv %b want 0 0 0", hx_sck, busy, data_valid);
    end
    checks++; if (raw_data !== 24'd0 || weight_out !== 24'd0) begin
      errors++; $display("FAIL rst_mid_data: raw %h weight %h want 0 0", raw_data, weight_out);
    end
    m_tare = 24'd0;
    m_armed = 1'b0;
    hx_dout = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    w = 24'($urandom);
    do_sample(0, w, p, got, after);
    model_commit(w, e);
    checks++; if (!got || raw_data !== w || weight_out !== e) begin
      errors++; $display("FAIL rst_mid_after: raw %h weight %h want %h %h (dv %b)", raw_data, weight_out, w, e, got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_tare();
    test_no_wrap();
    test_gain3();
    test_random();
    test_power_down();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
